// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the 5-stage pipeline and its stall/flush scheduler.
// master: pipeline side (drives hazard inputs, consumes register controls).
// slave:  scheduler side (pipe_hazard_ctrl).
interface pipe_hazard_ctrl_if;
    // Decode-stage operand usage
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    // Execute-stage producer and branch resolution
    logic       ex_valid;
    logic       ex_mem_read;
    logic [4:0] ex_rd;
    logic       branch_taken;
    // Data-memory handshake
    logic       dmem_req;
    logic       dmem_ready;
    logic       err_clr;
    // Pipeline register controls
    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        id_ex_hold;
    logic        ex_mem_hold;
    logic        if_id_flush;
    logic [1:0]  hz_state;
    logic        mem_timeout_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_mem_read, ex_rd, branch_taken,
        output dmem_req, dmem_ready, err_clr,
        input  pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, ex_mem_hold,
        input  if_id_flush, hz_state, mem_timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_mem_read, ex_rd, branch_taken,
        input  dmem_req, dmem_ready, err_clr,
        output pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, ex_mem_hold,
        output if_id_flush, hz_state, mem_timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage integer pipeline.
// Detects ID/EX load-use hazards, freezes the pipe while data memory is busy
// (bounded by a watchdog), and holds IF/ID flush + ID/EX bubble for
// FLUSH_CYCLES after a taken branch.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/flush counters;
// without it stall_cnt/flush_cnt are tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,   // 1..7
    parameter int unsigned MEM_TIMEOUT  = 255  // 1..65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pipe_hazard_ctrl_if.slave    hz_if
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam logic [2:0]  FlushReload = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] WaitLimit   = 16'(MEM_TIMEOUT);
    localparam bit          MultiFlush  = (FLUSH_CYCLES > 1);

    state_e      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;

    logic load_use;
    logic mem_busy;
    logic advance;   // unfrozen cycle: branch / load-use are evaluated as in RUN
    logic freeze;
    logic lu_stall;
    logic flush;
    logic err_set;

    // Hazard detection from the current ID/EX contents
    always_comb begin
        load_use = hz_if.id_valid & hz_if.ex_valid & hz_if.ex_mem_read &
                   (hz_if.ex_rd != 5'd0) &
                   ((hz_if.id_uses_rs1 & (hz_if.id_rs1 == hz_if.ex_rd)) |
                    (hz_if.id_uses_rs2 & (hz_if.id_rs2 == hz_if.ex_rd)));
        mem_busy = hz_if.dmem_req & ~hz_if.dmem_ready;
    end

    // Next-state and raw control decode; priority mem_busy > branch > load-use
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        wcnt_d   = wcnt_q;
        advance  = 1'b0;
        freeze   = 1'b0;
        lu_stall = 1'b0;
        flush    = 1'b0;
        err_set  = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_busy) begin
                    freeze  = 1'b1;
                    wcnt_d  = 16'd1;
                    state_d = StMemWait;
                end else begin
                    advance = 1'b1;
                end
            end
            StMemWait: begin
                if (mem_busy) begin
                    if (wcnt_q >= WaitLimit) begin
                        // Watchdog: give up on the access, let the pipe move
                        err_set = 1'b1;
                        wcnt_d  = 16'd0;
                        state_d = StRun;
                    end else begin
                        freeze = 1'b1;
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end else begin
                    advance = 1'b1;
                    wcnt_d  = 16'd0;
                    state_d = StRun;
                end
            end
            StFlush: begin
                flush = 1'b1;
                if (mem_busy) begin
                    // Flush window pauses while memory holds the pipe
                    freeze = 1'b1;
                end else if (hz_if.branch_taken) begin
                    fcnt_d  = FlushReload;
                    state_d = MultiFlush ? StFlush : StRun;
                end else begin
                    fcnt_d = (fcnt_q != 3'd0) ? fcnt_q - 3'd1 : 3'd0;
                    if (fcnt_q <= 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (advance) begin
            if (hz_if.branch_taken) begin
                flush = 1'b1;
                if (MultiFlush) begin
                    fcnt_d  = FlushReload;
                    state_d = StFlush;
                end else begin
                    state_d = StRun;
                end
            end else if (load_use) begin
                lu_stall = 1'b1;
            end
        end

        // Set wins over clear
        err_d = err_set | (err_q & ~hz_if.err_clr);
    end

    // State, counters and sticky watchdog flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StRun;
            fcnt_q  <= 3'd0;
            wcnt_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Control outputs, gated low while in reset
    always_comb begin
        hz_if.pc_stall        = reset_n & (freeze | lu_stall);
        hz_if.if_id_stall     = reset_n & (freeze | lu_stall);
        hz_if.id_ex_bubble    = reset_n & (flush | lu_stall);
        hz_if.id_ex_hold      = reset_n & freeze;
        hz_if.ex_mem_hold     = reset_n & freeze;
        hz_if.if_id_flush     = reset_n & flush;
        hz_if.hz_state        = state_q;
        hz_if.mem_timeout_err = err_q;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        flush_evt;

    assign flush_evt = ((state_q == StRun) || (state_q == StFlush)) &
                       hz_if.branch_taken & ~mem_busy;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (hz_if.pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz_if.stall_cnt = stall_cnt_q;
    assign hz_if.flush_cnt = flush_cnt_q;
`else
    assign hz_if.stall_cnt = 32'd0;
    assign hz_if.flush_cnt = 32'd0;
`endif

endmodule
